// File: rtl/count_arbiter.sv
// Round-robin arbiter sharing one tri-state up-counter between two clients.
// Each grant advances the counter STEPS counts, then reads Q back to the winner.
module count_arbiter #(
   parameter int WIDTH  = 16,
   parameter int STEPS  = 4,
   parameter int STEP_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req,
   output logic [1:0]       gnt,
   output logic [1:0]       done,
   output logic [WIDTH-1:0] rd_data,
   output logic             wrapped,
   output logic             cnt_n_cen,
   output logic             cnt_n_op_en,
   input  logic [WIDTH-1:0] cnt_q,
   input  logic             cnt_rel,
   output logic [1:0]       o_dbg_state
);

   // Handshake: a client holds req high; it owns the counter while gnt[i] is high,
   // and done[i] pulses for one cycle with rd_data/wrapped valid. req is only
   // sampled in IDLE, so dropping or changing it mid-transaction has no effect.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COUNT  = 2'd1,
      SETTLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [STEP_W-1:0] r_step;
   logic [STEP_W-1:0] w_step_nxt;
   logic              r_last;
   logic              w_last_nxt;
   logic [1:0]        r_gnt;
   logic [1:0]        w_gnt_nxt;
   logic [1:0]        r_done;
   logic [1:0]        w_done_nxt;
   logic [WIDTH-1:0]  r_rd_data;
   logic [WIDTH-1:0]  w_rd_nxt;
   logic              r_wrapped;
   logic              w_wrap_nxt;
   logic              r_n_cen;
   logic              w_n_cen_nxt;
   logic              r_n_op_en;
   logic              w_n_op_en_nxt;
   logic              w_start;
   logic              w_win;

   assign w_start = (r_state == IDLE) && (req != 2'b00);
   // On contention the client that was not granted last wins; r_last resets to 1 so client 0 goes first.
   assign w_win   = (req == 2'b11) ? ~r_last : req[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_step    <= '0;
         r_last    <= 1'b1;
         r_gnt     <= 2'b00;
         r_done    <= 2'b00;
         r_rd_data <= '0;
         r_wrapped <= 1'b0;
         r_n_cen   <= 1'b1;
         r_n_op_en <= 1'b1;
      end else begin
         r_state   <= w_next;
         r_step    <= w_step_nxt;
         r_last    <= w_last_nxt;
         r_gnt     <= w_gnt_nxt;
         r_done    <= w_done_nxt;
         r_rd_data <= w_rd_nxt;
         r_wrapped <= w_wrap_nxt;
         r_n_cen   <= w_n_cen_nxt;
         r_n_op_en <= w_n_op_en_nxt;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_start) w_next = COUNT;
         COUNT:   if (r_step == STEP_W'(1)) w_next = SETTLE;
         SETTLE:  w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every pin comes straight from a flop.
   always_comb begin
      w_step_nxt    = r_step;
      w_last_nxt    = r_last;
      w_gnt_nxt     = r_gnt;
      w_done_nxt    = 2'b00;
      w_rd_nxt      = r_rd_data;
      w_wrap_nxt    = r_wrapped;
      w_n_cen_nxt   = (w_next != COUNT);
      w_n_op_en_nxt = (w_next != SETTLE);
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_gnt_nxt  = w_win ? 2'b10 : 2'b01;
               w_last_nxt = w_win;
               w_step_nxt = STEP_W'(STEPS);
               w_wrap_nxt = 1'b0;
            end
         end
         COUNT: begin
            w_step_nxt = r_step - STEP_W'(1);
            if (cnt_rel) w_wrap_nxt = 1'b1;
         end
         SETTLE: begin
            w_rd_nxt   = cnt_q;
            w_done_nxt = r_gnt;
            if (cnt_rel) w_wrap_nxt = 1'b1;
         end
         DONE: begin
            w_gnt_nxt = 2'b00;
         end
         default: begin
            w_gnt_nxt = 2'b00;
         end
      endcase
   end

   assign gnt         = r_gnt;
   assign done        = r_done;
   assign rd_data     = r_rd_data;
   assign wrapped     = r_wrapped;
   assign cnt_n_cen   = r_n_cen;
   assign cnt_n_op_en = r_n_op_en;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_count_arbiter.sv
// Bench for count_arbiter: a mod-16 tri-state counter stub plus a transaction-level
// model of grants, timing and captured values, driven by directed and random requests.
module tb_count_arbiter;

   localparam int WIDTH   = 16;
   localparam int STEPS   = 4;
   localparam int STEP_W  = 8;
   localparam int CNT_MOD = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       req = 2'b00;
   logic [1:0]       gnt;
   logic [1:0]       done;
   logic [WIDTH-1:0] rd_data;
   logic             wrapped;
   logic             cnt_n_cen;
   logic             cnt_n_op_en;
   logic             cnt_rel;
   logic [1:0]       dbg_state;
   wire  [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] dev_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   count_arbiter #(.WIDTH(WIDTH), .STEPS(STEPS), .STEP_W(STEP_W)) dut (
      .clk         (clk),
      .reset       (rst_n),
      .req         (req),
      .gnt         (gnt),
      .done        (done),
      .rd_data     (rd_data),
      .wrapped     (wrapped),
      .cnt_n_cen   (cnt_n_cen),
      .cnt_n_op_en (cnt_n_op_en),
      .cnt_q       (cnt_q),
      .cnt_rel     (cnt_rel),
      .o_dbg_state (dbg_state)
   );

   // Counter device: counts while n_cen is low, rel pulses the cycle after a wrap.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dev_cnt <= '0;
         cnt_rel <= 1'b0;
      end else if (!cnt_n_cen) begin
         dev_cnt <= (dev_cnt == WIDTH'(CNT_MOD - 1)) ? '0 : dev_cnt + WIDTH'(1);
         cnt_rel <= (dev_cnt == WIDTH'(CNT_MOD - 1));
      end else begin
         cnt_rel <= 1'b0;
      end
   end

   assign cnt_q = cnt_n_op_en ? 'z : dev_cnt;

   // ---------------- check task ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // ---------------- reference model ----------------
   int               m_cnt  = 0;
   int               m_k    = 0;
   int               m_win  = 0;
   int               m_last = 1;
   bit               m_busy = 1'b0;
   logic [1:0]       e_gnt  = 2'b00;
   logic [1:0]       e_done = 2'b00;
   logic             e_n_cen = 1'b1;
   logic             e_n_op_en = 1'b1;
   logic [WIDTH-1:0] e_rd   = '0;
   logic [WIDTH-1:0] exp_q[$];
   logic             wrap_q[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  = 0;
         m_k    = 0;
         m_win  = 0;
         m_last = 1;
         m_busy = 1'b0;
         e_rd   = '0;
         exp_q.delete();
         wrap_q.delete();
      end else begin
         if (m_busy) begin
            m_k++;
            if (m_k == STEPS + 2) m_busy = 1'b0;
         end else if (req != 2'b00) begin
            if (req == 2'b11) m_win = 1 - m_last;
            else              m_win = req[0] ? 0 : 1;
            m_last = m_win;
            m_busy = 1'b1;
            m_k    = 0;
            wrap_q.push_back(m_cnt + STEPS >= CNT_MOD);
            m_cnt = (m_cnt + STEPS) % CNT_MOD;
            exp_q.push_back(WIDTH'(m_cnt));
         end
         if (m_busy && m_k == STEPS + 1) e_rd = WIDTH'(m_cnt);
      end
      e_gnt     = m_busy ? ((m_win == 1) ? 2'b10 : 2'b01) : 2'b00;
      e_done    = (m_busy && m_k == STEPS + 1) ? e_gnt : 2'b00;
      e_n_cen   = !(m_busy && m_k < STEPS);
      e_n_op_en = !(m_busy && m_k == STEPS);
   end

   // ---------------- scoreboard / per-cycle monitor ----------------
   always @(negedge clk) begin
      check("gnt", 32'(gnt), 32'(e_gnt));
      check("done", 32'(done), 32'(e_done));
      check("n_cen", 32'(cnt_n_cen), 32'(e_n_cen));
      check("n_op_en", 32'(cnt_n_op_en), 32'(e_n_op_en));
      check("rd_hold", 32'(rd_data), 32'(e_rd));
      check("no_contention", 32'(cnt_n_cen | cnt_n_op_en), 32'(1));
      if (done != 2'b00) begin
         check("sb_nonempty", 32'(exp_q.size() != 0), 32'(1));
         if (exp_q.size() != 0) begin
            check("sb_rd", 32'(rd_data), 32'(exp_q.pop_front()));
            check("sb_wrap", 32'(wrapped), 32'(wrap_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic reset_dut();
      @(negedge clk);
      #2 rst_n = 1'b0;
      req = 2'b00;
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic wait_done(output int cycles, output logic [1:0] d);
      cycles = 0;
      d      = 2'b00;
      while (cycles < 60 && d == 2'b00) begin
         @(negedge clk);
         cycles++;
         d = done;
      end
      check("done_seen", 32'(d != 2'b00), 32'(1));
   endtask

   task automatic wait_count_start();
      int n = 0;
      logic seen = 1'b0;
      while (n < 20 && !seen) begin
         @(negedge clk);
         n++;
         seen = !cnt_n_cen;
      end
      check("count_seen", 32'(seen), 32'(1));
   endtask

   // ---------------- stimulus ----------------
   logic [1:0]       rr_exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
   logic [WIDTH-1:0] rr_exp_rd  [4] = '{16'h0004, 16'h0008, 16'h000C, 16'h0000};
   logic             rr_exp_wrap[4] = '{1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      int         cyc;
      logic [1:0] d;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;

      // Idle after reset: nothing moves for ten cycles.
      repeat (10) @(negedge clk);
      check("idle_gnt", 32'(gnt), 32'(0));
      check("idle_n_op_en", 32'(cnt_n_op_en), 32'(1));

      // Single requester.
      req = 2'b01;
      wait_done(cyc, d);
      check("t1_latency", 32'(cyc), 32'(STEPS + 2));
      check("t1_done", 32'(d), 32'(2'b01));
      check("t1_rd", 32'(rd_data), 32'(16'h0004));
      check("t1_wrap", 32'(wrapped), 32'(0));
      req = 2'b00;
      repeat (4) @(negedge clk);

      // Both requesting: alternation, fixed spacing, wrap on the fourth.
      reset_dut();
      req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         wait_done(cyc, d);
         check("rr_gap", 32'(cyc), 32'((i == 0) ? STEPS + 2 : STEPS + 3));
         check("rr_gnt", 32'(d), 32'(rr_exp_gnt[i]));
         check("rr_rd", 32'(rd_data), 32'(rr_exp_rd[i]));
         check("rr_wrap", 32'(wrapped), 32'(rr_exp_wrap[i]));
      end
      req = 2'b00;
      repeat (STEPS + 4) @(negedge clk);

      // Request dropped after the first COUNT cycle.
      req = 2'b01;
      wait_count_start();
      req = 2'b00;
      wait_done(cyc, d);
      check("drop_done", 32'(d), 32'(2'b01));
      check("drop_rd", 32'(rd_data), 32'(16'h0004));
      repeat (10) @(negedge clk);
      check("drop_no_gnt", 32'(gnt), 32'(0));

      // Reset in the middle of COUNT.
      req = 2'b10;
      wait_count_start();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_gnt", 32'(gnt), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_n_cen", 32'(cnt_n_cen), 32'(1));
      check("rst_n_op_en", 32'(cnt_n_op_en), 32'(1));
      check("rst_rd", 32'(rd_data), 32'(0));
      check("rst_wrap", 32'(wrapped), 32'(0));
      @(negedge clk);
      #2 rst_n = 1'b1;
      req = 2'b10;
      wait_done(cyc, d);
      check("post_rst_done", 32'(d), 32'(2'b10));
      check("post_rst_rd", 32'(rd_data), 32'(16'h0004));
      req = 2'b00;
      repeat (4) @(negedge clk);

      // Random request patterns.
      repeat (300) begin
         req = 2'($urandom_range(0, 3));
         repeat ($urandom_range(1, 8)) @(negedge clk);
      end
      req = 2'b00;
      repeat (STEPS + 6) @(negedge clk);
      check("sb_drained", 32'(exp_q.size()), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
